i2c_pattern_tester: RTL and testbench

//  Cycle-based vector engine for a two-pin I2C interface (SCL, SDA), in the style of an ATE pin channel.

---
 rtl/i2c_pattern_tester.sv | 146 ++++++++++++++
 tb/tb_i2c_pattern_tester.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pattern_tester.sv
// Cycle-based two-pin (SCL/SDA) vector engine: applies drive/compare codes per tester
// cycle, strobes synchronized pad levels and keeps saturating logger/pattern counters.
module i2c_pattern_tester #(
  parameter int unsigned CYCLE_CLKS = 4,
  parameter int unsigned STROBE_CLK = 2,
  parameter int unsigned REP_W      = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [2:0]       vec_scl,
  input  logic [2:0]       vec_sda,
  input  logic [REP_W-1:0] vec_repeat,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             running,
  output logic [CNT_W-1:0] cycle_number,
  output logic [CNT_W-1:0] vector_number,
  output logic [REP_W-1:0] repeat_count,
  output logic [CNT_W-1:0] compare_number,
  output logic [CNT_W-1:0] fail_number,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_vec
);
  localparam int unsigned PH_W = (CYCLE_CLKS > 1) ? $clog2(CYCLE_CLKS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, next_state;
  logic [PH_W-1:0] phase;
  logic [2:0]      scl_code, sda_code;
  logic [1:0]      scl_sync, sda_sync;
  logic            have_vec;
  logic            last, accept, strobe;
  logic            scl_chk, sda_chk, scl_miss, sda_miss;
  logic [1:0]      n_cmp, n_fail;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign running   = (state == RUN);
  assign last      = (phase == PH_W'(CYCLE_CLKS - 1));
  assign vec_ready = !running || (last && repeat_count == '0);
  assign accept    = vec_valid && vec_ready;
  assign strobe    = running && (phase == PH_W'(STROBE_CLK));

  // Only codes 010/011 compare; bit 0 is the expected level.
  assign scl_chk  = !scl_code[2] && scl_code[1];
  assign sda_chk  = !sda_code[2] && sda_code[1];
  assign scl_miss = scl_chk && (scl_sync[1] != scl_code[0]);
  assign sda_miss = sda_chk && (sda_sync[1] != sda_code[0]);
  assign n_cmp    = {1'b0, scl_chk} + {1'b0, sda_chk};
  assign n_fail   = {1'b0, scl_miss} + {1'b0, sda_miss};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN:  if (last && repeat_count == '0 && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      scl_code     <= 3'b100;
      sda_code     <= 3'b100;
      scl_sync     <= '0;
      sda_sync     <= '0;
      repeat_count <= '0;
      scl_oe       <= 1'b0;
      sda_oe       <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      if (accept) begin
        phase        <= '0;
        scl_code     <= vec_scl;
        sda_code     <= vec_sda;
        repeat_count <= vec_repeat;
        scl_oe       <= (vec_scl == 3'b000);
        sda_oe       <= (vec_sda == 3'b000);
      end else if (running) begin
        phase <= last ? '0 : phase + 1'b1;
        if (last) begin
          if (repeat_count != '0) begin
            repeat_count <= repeat_count - 1'b1;
          end else begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
          end
        end
      end
    end
  end

  // Statistics: clr has priority over any strobe or cycle-end in the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_number   <= '0;
      vector_number  <= '0;
      compare_number <= '0;
      fail_number    <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
      have_vec       <= 1'b0;
    end else if (clr) begin
      cycle_number   <= '0;
      vector_number  <= '0;
      compare_number <= '0;
      fail_number    <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
      have_vec       <= 1'b0;
    end else begin
      if (accept) begin
        have_vec <= 1'b1;
        if (have_vec) vector_number <= sat_add(vector_number, 2'd1);
      end
      if (running && last) cycle_number <= sat_add(cycle_number, 2'd1);
      if (strobe) begin
        compare_number <= sat_add(compare_number, n_cmp);
        fail_number    <= sat_add(fail_number, n_fail);
        if ((scl_miss || sda_miss) && !fail_seen) begin
          fail_seen      <= 1'b1;
          first_fail_vec <= vector_number;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_pattern_tester.sv
// Directed + randomized bench for i2c_pattern_tester; counters checked against
// a per-vector arithmetic model (cycles = rep+1, compares per CL/CH pin per cycle).
module tb_i2c_pattern_tester;
  logic        clk = 1'b0;
  logic        rst, clr, vec_valid, vec_ready;
  logic [2:0]  vec_scl, vec_sda;
  logic [15:0] vec_repeat;
  logic        scl_in, sda_in, scl_oe, sda_oe, running, fail_seen;
  logic [31:0] cycle_number, vector_number, compare_number, fail_number, first_fail_vec;
  logic [15:0] repeat_count;
  logic        ext_scl, ext_sda;

  int unsigned total = 0, passes = 0, fails = 0;
  longint unsigned run_clks = 0;

  i2c_pattern_tester #(.CYCLE_CLKS(4), .STROBE_CLK(2), .REP_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_scl(vec_scl), .vec_sda(vec_sda), .vec_repeat(vec_repeat),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .running(running), .cycle_number(cycle_number), .vector_number(vector_number),
    .repeat_count(repeat_count), .compare_number(compare_number),
    .fail_number(fail_number), .fail_seen(fail_seen), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  // Open-drain pads: device side drives ext_*, engine pulls low with oe.
  assign scl_in = ext_scl & ~scl_oe;
  assign sda_in = ext_sda & ~sda_oe;

  always @(negedge clk) if (running) run_clks <= run_clks + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one vector alone and waits for the engine to go idle.
  task automatic send_vec(input logic [2:0] s, input logic [2:0] d, input logic [15:0] rep,
                          output int unsigned oe_clks, output int unsigned sda_clks);
    int unsigned n;
    oe_clks = 0; sda_clks = 0;
    @(negedge clk);
    vec_scl = s; vec_sda = d; vec_repeat = rep; vec_valid = 1'b1;
    n = 0;
    while (!vec_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    n = 0;
    while (running && n < 1000) begin
      if (scl_oe) oe_clks++;
      if (sda_oe) sda_clks++;
      @(negedge clk); n++;
    end
    if (n >= 1000) check("timeout_idle", 64'(running), 64'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    int unsigned oc, sc, n;
    longint unsigned rc0;
    longint unsigned m_cyc, m_cmp, m_fail, m_ffv, m_nacc;
    logic m_seen;
    logic [2:0] rs, rd;
    logic [15:0] rr;

    rst = 1'b1; clr = 1'b0; vec_valid = 1'b0; vec_scl = 3'b100; vec_sda = 3'b100;
    vec_repeat = '0; ext_scl = 1'b1; ext_sda = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_scl_oe", 64'(scl_oe), 0);
    check("rst_sda_oe", 64'(sda_oe), 0);
    check("rst_ready", 64'(vec_ready), 1);
    check("rst_running", 64'(running), 0);
    check("rst_counters", 64'(cycle_number | vector_number | compare_number | fail_number
                              | first_fail_vec | 32'(repeat_count) | 32'(fail_seen)), 0);

    // Single D0/D1 vector: SCL pulled low for exactly one tester cycle.
    send_vec(3'b000, 3'b001, 16'd0, oc, sc);
    check("d0_oe_clks", 64'(oc), 4);
    check("d1_sda_clks", 64'(sc), 0);
    check("d0_cycles", 64'(cycle_number), 1);
    check("d0_compares", 64'(compare_number), 0);
    check("d0_oe_after", 64'(scl_oe), 0);

    // CH/CL with matching bus, 3 cycles.
    ext_scl = 1'b1; ext_sda = 1'b0;
    send_vec(3'b011, 3'b010, 16'd2, oc, sc);
    check("match_compares", 64'(compare_number), 6);
    check("match_fails", 64'(fail_number), 0);
    check("match_cycles", 64'(cycle_number), 4);
    check("match_vecnum", 64'(vector_number), 1);
    check("match_seen", 64'(fail_seen), 0);

    // Same vector with SDA high: one SDA fail per cycle.
    pulse_clr();
    ext_sda = 1'b1;
    send_vec(3'b011, 3'b010, 16'd2, oc, sc);
    check("miss_fails", 64'(fail_number), 3);
    check("miss_compares", 64'(compare_number), 6);
    check("miss_seen", 64'(fail_seen), 1);
    check("miss_ffv", 64'(first_fail_vec), 0);
    check("miss_cycles", 64'(cycle_number), 3);

    // Back-to-back stream: valid held high, no idle clocks between vectors.
    pulse_clr();
    rc0 = run_clks;
    @(negedge clk);
    vec_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      vec_scl = (i[0]) ? 3'b001 : 3'b000; vec_sda = 3'b101; vec_repeat = '0;
      n = 0;
      while (!vec_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
    end
    vec_valid = 1'b0;
    n = 0;
    while (running && n < 100) begin @(negedge clk); n++; end
    check("b2b_vecnum", 64'(vector_number), 4);
    check("b2b_cycles", 64'(cycle_number), 5);
    check("b2b_run_clks", 64'(run_clks - rc0), 20);

    // clr on a failing strobe: discarded, pattern keeps going.
    pulse_clr();
    ext_scl = 1'b0;
    @(negedge clk);
    vec_scl = 3'b011; vec_sda = 3'b100; vec_repeat = 16'd1; vec_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); vec_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_compares", 64'(compare_number), 0);
    check("clr_fails", 64'(fail_number), 0);
    check("clr_seen", 64'(fail_seen), 0);
    check("clr_running", 64'(running), 1);
    check("clr_repeat", 64'(repeat_count), 1);
    n = 0;
    while (running && n < 100) begin @(negedge clk); n++; end
    check("clr_after_cycles", 64'(cycle_number), 2);
    check("clr_after_compares", 64'(compare_number), 1);
    check("clr_after_fails", 64'(fail_number), 1);
    check("clr_after_ffv", 64'(first_fail_vec), 0);

    // Async reset mid-vector.
    @(negedge clk);
    vec_scl = 3'b000; vec_sda = 3'b000; vec_repeat = 16'd5; vec_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); vec_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_oe", 64'(scl_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_scl_oe", 64'(scl_oe), 0);
    check("async_rst_sda_oe", 64'(sda_oe), 0);
    check("async_rst_running", 64'(running), 0);
    @(negedge clk); rst = 1'b0;

    // Randomized single vectors against the arithmetic model.
    m_cyc = 0; m_cmp = 0; m_fail = 0; m_ffv = 0; m_nacc = 0; m_seen = 1'b0;
    for (int unsigned k = 0; k < 30; k++) begin
      rs = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
      rr = 16'($urandom_range(0, 3));
      ext_scl = 1'($urandom); ext_sda = 1'($urandom);
      send_vec(rs, rd, rr, oc, sc);
      m_nacc++;
      m_cyc += rr + 1;
      if (rs[2:1] == 2'b01) begin
        m_cmp += rr + 1;
        if (ext_scl != rs[0]) m_fail += rr + 1;
      end
      if (rd[2:1] == 2'b01) begin
        m_cmp += rr + 1;
        if (ext_sda != rd[0]) m_fail += rr + 1;
      end
      if (m_fail != 0 && !m_seen) begin m_seen = 1'b1; m_ffv = m_nacc - 1; end
      check("rnd_scl_oe_clks", 64'(oc), (rs == 3'b000) ? 64'(4 * (rr + 1)) : 64'd0);
      check("rnd_cycles", 64'(cycle_number), m_cyc);
      check("rnd_vecnum", 64'(vector_number), m_nacc - 1);
      check("rnd_compares", 64'(compare_number), m_cmp);
      check("rnd_fails", 64'(fail_number), m_fail);
      check("rnd_seen", 64'(fail_seen), 64'(m_seen));
      check("rnd_ffv", 64'(first_fail_vec), m_ffv);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
